// File: rtl/four_to_two_priority_request_controller.sv
// rtl/four_to_two_priority_request_controller.sv - sticky request capture with 4:2 priority presentation and valid/ack handshake
// Rising edges set pending bits; the highest unmasked pending bit is presented as a frozen code until ack or timeout.
module four_to_two_priority_request_controller #(
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_in,
   input  logic [3:0] mask,
   input  logic       ack,
   output logic       valid,
   output logic [1:0] code,
   output logic [3:0] pending,
   output logic       overflow,
   output logic       timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESENT = 2'd1,
      S_GAP     = 2'd2
   } state_t;

   localparam bit         TO_EN    = (TIMEOUT != 0);
   localparam logic [3:0] CNT_LAST = TO_EN ? 4'(TIMEOUT - 1) : 4'd0;

   state_t     state_q, state_d;
   logic [1:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic [3:0] pending_q, pending_d;
   logic [3:0] req_q;
   logic       overflow_q, overflow_d;
   logic       timeout_q, timeout_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] rise;
   logic [3:0] clr;
   logic [3:0] eligible;

   function automatic logic [1:0] top_index(input logic [3:0] v);
      logic [1:0] idx;
      if (v[3])      idx = 2'd3;
      else if (v[2]) idx = 2'd2;
      else if (v[1]) idx = 2'd1;
      else           idx = 2'd0;
      return idx;
   endfunction

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      clr       = 4'b0000;
      eligible  = pending_q & ~mask;
      rise      = req_in & ~req_q;

      case (state_q)
         S_IDLE: begin
            if (|eligible) begin
               code_d  = top_index(eligible);
               cnt_d   = 4'd0;
               state_d = S_PRESENT;
               valid_d = 1'b1;
            end
         end
         S_PRESENT: begin
            valid_d = 1'b1;
            // ack takes precedence over an expiring timeout on the same edge
            if (ack) begin
               clr     = 4'b0001 << code_q;
               state_d = S_GAP;
               valid_d = 1'b0;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
               valid_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // a fresh rise on the bit being cleared keeps it set and is not an overflow
      pending_d  = (pending_q & ~clr) | rise;
      overflow_d = |(rise & pending_q & ~clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         code_q     <= 2'b00;
         valid_q    <= 1'b0;
         pending_q  <= 4'b0000;
         req_q      <= 4'b0000;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         cnt_q      <= 4'd0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         pending_q  <= pending_d;
         req_q      <= req_in;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
         cnt_q      <= cnt_d;
      end
   end

   assign valid    = valid_q;
   assign code     = code_q;
   assign pending  = pending_q;
   assign overflow = overflow_q;
   assign timeout  = timeout_q;

endmodule

// File: doc/four_to_two_priority_request_controller.md
# four_to_two_priority_request_controller

Sequential front end for the 4:2 priority encoder path. It captures rising edges on four request lines into sticky pending bits and masks them. It presents the highest-priority unmasked request as a stable 2-bit code with a valid/ack handshake, and clears the served request on acknowledge. Bit 3 (d) has the highest priority and bit 0 (a) the lowest, the same ordering as the combinational priority encoder this block feeds.

## Interface
Parameters:
- TIMEOUT, 8: maximum cycles valid is held without ack; 0 disables the timeout. Counter is 4 bits wide; legal range is 0..15.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_in  input  4  request lines, level inputs; a rising edge (0 to 1) registers a request.
- mask  input  4  1 = request bit ignored for selection; it may still pend.
- ack  input  1  consumer acknowledge; sampled only while valid = 1.
- valid  output  1  code is presenting a request.
- code  output  2  index of the presented request (3 = d … 0 = a).
- pending  output  4  sticky pending request bits.
- overflow  output  1  1-cycle pulse: a rising edge arrived on a bit that was already pending.
- timeout  output  1  1-cycle pulse: presentation abandoned without ack.

## Operation
- Edge detect: req_d is the registered req_in. rise = req_in & ~req_d.
- Pending update each edge: pending <= (pending & ~clr) | rise. clr is a one-hot clear of code, asserted only on an accepted ack.
- Set wins over clear. A rise on the bit being cleared in the same cycle leaves that bit set, with no overflow.
- overflow = |(rise & pending & ~clr), registered, 1 cycle.
- FSM states:
  - IDLE: valid = 0. If (pending & ~mask) != 0, latch code = index of the highest set bit and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: valid = 1, code frozen. A later mask change or a higher-priority arrival does not change code.
    - If ack is sampled: clear pending[code] and go to GAP.
    - Else if TIMEOUT != 0 and cnt == TIMEOUT-1: pulse timeout, keep pending, and go to IDLE.
    - Else increment cnt. cnt clears on PRESENT entry.
  - GAP: valid = 0, one cycle, then IDLE.
- ack and timeout at the same edge: ack wins and no timeout pulse is generated.
- ack while not valid: ignored.
- Reset (at any time, including mid-PRESENT) sets:
  - state = IDLE
  - valid = 0, code = 2'b00
  - pending = 4'b0000, req_d = 4'b0000
  - overflow = 0, timeout = 0, cnt = 0
- Because req_d resets to 0, a req_in held high through reset release registers as a rise on the first edge after release.

## Timing
- Request to valid: req_in rises before edge k, pending is set after edge k, and valid/code are set after edge k+1. Latency is 2 cycles.
- Ack to next valid: ack is sampled at edge a. valid = 0 after edge a (GAP) and after edge a+1 (IDLE), and valid = 1 after edge a+2 if work remains. valid is low for at least 2 cycles between presentations.
- Timeout: valid stays high for exactly TIMEOUT cycles, then goes low with timeout = 1 for that one cycle. The request can be re-presented 1 cycle later.
- code is stable for the whole valid-high interval. pending is updated every edge regardless of state.
- All outputs are registered; there is no combinational path from an input to an output.

## Test plan
- Reset, then req_in = 4'b0101 (rises before edge 1). Required: pending = 0101 after edge 1; valid = 1 with code = 2 after edge 2. Ack at edge 3 gives pending = 0001. valid returns high with code = 0 after edge 5.
- mask = 4'b1000, req_in rises to 4'b1010. Required: code = 1 presented. Clearing mask while valid leaves code = 1. After ack, code = 3 is presented.
- TIMEOUT = 3, single request on bit 2, ack never asserted. Required: valid is high for 3 cycles, then valid = 0 with timeout = 1 for 1 cycle. pending[2] stays 1, and code = 2 is re-presented.
- While pending[1] = 1 (not being served), req_in[1] toggles 0→1. Required: overflow = 1 for 1 cycle, pending unchanged. The same rise coinciding with an ack of code = 1 gives pending[1] = 1 and overflow = 0.
- rst asserted mid-PRESENT with req_in held at 4'b0010. Required: valid = 0, pending = 0, code = 0 the edge after reset. After release, pending[1] = 1 one edge later and valid = 1 one edge after that.
